// File: rtl/pc_ifu_pkg.sv
// pc_ifu_pkg: shared state encoding, word width and reset PC for the fetch unit.
package pc_ifu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ERR = 2'd2} state_t;
endpackage

// File: rtl/ifu_timeout_cnt.sv
// ifu_timeout_cnt: wait-cycle counter with clear/enable; expire flags the last allowed cycle (LIMIT=0 never expires).
module ifu_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : en ? cnt_q + 32'd1 : cnt_q;
  assign expire = (LIMIT != 0) && (cnt_q == 32'(LIMIT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pc_ifu.sv
// pc_ifu: PC register plus req/ack instruction fetch with IR and sticky bus error.
// Optional IFU_ALIGN_CHK_EN: misaligned fetch goes to ERR instead of masking pc[1:0].
module pc_ifu
  import pc_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] nxtpc,
  input  logic            pc_wr,
  input  logic            fetch_start,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_add4,
  output logic [XLEN-1:0] ir,
  output logic            fetch_done,
  output logic            busy,
  output logic            bus_err
);
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, ir_q, ir_d, addr_q, addr_d;
  logic req_q, req_d, done_q, done_d, err_q, err_d, expire;
  ifu_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_q != REQ),
    .en(state_q == REQ),
    .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    pc_d = (pc_wr && state_q != REQ) ? nxtpc : pc_q;
    ir_d = ir_q;
    addr_d = addr_q;
    req_d = req_q;
    done_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: if (fetch_start) begin
`ifdef IFU_ALIGN_CHK_EN
        if (pc_q[1:0] != 2'b00) begin
          state_d = ERR;
          err_d = 1'b1;
        end else begin
          state_d = REQ;
          req_d = 1'b1;
          addr_d = pc_q;
        end
`else
        state_d = REQ;
        req_d = 1'b1;
        addr_d = {pc_q[XLEN-1:2], 2'b00};
`endif
      end
      REQ: if (imem_ack) begin
        state_d = IDLE;
        ir_d = imem_rdata;
        req_d = 1'b0;
        done_d = 1'b1;
      end else if (expire) begin
        state_d = ERR;
        req_d = 1'b0;
        err_d = 1'b1;
      end
      default: req_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ir_q <= '0;
      addr_q <= '0;
      req_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      addr_q <= addr_d;
      req_q <= req_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign pc = pc_q;
  assign pc_add4 = pc_q + 32'd4;
  assign ir = ir_q;
  assign fetch_done = done_q;
  assign busy = state_q == REQ;
  assign bus_err = err_q;
endmodule

// File: doc/pc_ifu.md
Name: pc_ifu

Overview:
Program counter register and instruction fetch unit for the multi-cycle MIPS core.
- Sits directly downstream of the next-PC calculator: holds the current PC, captures nxtpc on the controller's PC write strobe, and feeds curpc back.
- Runs a req/ack fetch handshake to instruction memory, latches the instruction register (IR), and pulses fetch_done to the controller FSM.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset.
TIMEOUT_CYC, 16, max cycles to wait for imem_ack before flagging bus error; 0 disables timeout.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
nxtpc  in  32  next PC from next-PC calculator.
pc_wr  in  1  controller PC write strobe.
fetch_start  in  1  controller request to fetch instruction at current PC.
imem_rdata  in  32  instruction word from memory.
imem_ack  in  1  memory ack; imem_rdata valid in the same cycle.
imem_req  out  1  fetch request to memory.
imem_addr  out  32  fetch address (word-aligned byte address).
pc  out  32  current PC (curpc to the next-PC calculator).
pc_add4  out  32  pc + 4, combinational.
ir  out  32  instruction register.
fetch_done  out  1  one-cycle pulse: IR updated.
busy  out  1  high in REQ state.
bus_err  out  1  sticky fetch error.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, ir=0, imem_req=0, imem_addr=0, fetch_done=0, bus_err=0, timeout counter=0, state=IDLE.
- States: IDLE, REQ, ERR.
- IDLE:
  - fetch_start=1 → REQ next edge; imem_addr<=pc (pre-update value); imem_req<=1; counter<=0.
- REQ:
  - imem_req=1 and imem_addr stable until ack.
  - imem_ack=1 → ir<=imem_rdata; imem_req<=0; fetch_done=1 for exactly the next cycle; → IDLE.
  - No ack → counter increments. If TIMEOUT_CYC≠0 and counter reaches TIMEOUT_CYC-1 with no ack that cycle → ERR; imem_req<=0; bus_err<=1.
  - fetch_start in REQ is ignored.
- ERR:
  - Absorbing until rst; imem_req=0; ir holds; bus_err=1.
  - pc_wr is still honored so debug can observe PC.
- PC update:
  - pc_wr=1 in IDLE or ERR → pc<=nxtpc next edge.
  - pc_wr=1 in REQ is ignored; pc holds.
- Simultaneous pc_wr and fetch_start in IDLE: the fetch uses the old pc; pc takes nxtpc on the same edge.
- imem_ack outside REQ: ignored, no IR change.
- ir changes only on an accepted ack.
- pc_add4 = pc + 4, mod 2^32 (wraps 32'hFFFF_FFFC → 0).
- Latency: minimum fetch is fetch_start at edge N → imem_req high cycle N+1 → ack in the same cycle → ir valid and fetch_done at N+2.
- rst mid-REQ: immediate return to reset values; any in-flight ack is dropped.

Optional Feature:
Macro IFU_ALIGN_CHK_EN.
- Defined: fetch_start in IDLE with pc[1:0]≠0 → no request is issued; state→ERR; bus_err=1 next edge.
- Not defined: pc[1:0] is forced to 0 on imem_addr; no alignment check.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, REQ=2'd1, ERR=2'd2), RESET_PC default, word width 32.
- Sub-module ifu_timeout_cnt: counter with clear, enable, and expire output.

Test Plan:
- Reset then fetch_start, ack after 2 wait cycles with rdata=32'h2408_0005 → imem_addr=32'h3000, ir=32'h2408_0005, single fetch_done pulse, pc unchanged.
- pc_wr with nxtpc=32'h3004 in IDLE, then fetch → imem_addr=32'h3004, pc_add4=32'h3008.
- pc_wr pulsed during REQ with nxtpc=32'h4000 → pc stays 32'h3000; after ack, pc_wr applies normally.
- TIMEOUT_CYC=16, never ack → imem_req drops after 16 cycles, bus_err=1, later ack ignored, ir unchanged.
- rst asserted mid-REQ → imem_req=0, pc=32'h3000 asynchronously; a subsequent normal fetch succeeds.
- IFU_ALIGN_CHK_EN defined, pc_wr nxtpc=32'h3002, fetch_start → no imem_req, bus_err=1.
